// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, synchronous flush/hold and a
// wrapping transfer counter. Define PIPE_SKID_EN for a second (skid) entry that makes in_ready a registered signal.
module pipe_stage_hs #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, emit;

    assign out_valid = main_v_q && !hold;
    assign out_data  = main_d_q;
    assign xfer_cnt  = cnt_q;
    assign emit      = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    // A flush cycle never counts as a transfer, even with out_ready high.
    always_comb begin
        cnt_d = cnt_q;
        if (emit && !flush)
            cnt_d = cnt_q + CNT_W'(1);
    end

`ifdef PIPE_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;

    // Only registered state (plus hold) feeds in_ready; out_ready has no path here.
    assign in_ready = !skid_v_q && !hold;

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = RESET_VAL;
            skid_v_d = 1'b0;
            skid_d_d = RESET_VAL;
        end else if (!hold) begin
            if (emit) begin
                if (skid_v_q) begin
                    main_v_d = 1'b1;
                    main_d_d = skid_d_q;
                    skid_v_d = accept;
                    if (accept)
                        skid_d_d = in_data;
                end else if (accept) begin
                    main_v_d = 1'b1;
                    main_d_d = in_data;
                end else begin
                    main_v_d = 1'b0;
                end
            end else if (accept) begin
                // Main busy and stalled: park the new payload in the skid entry.
                if (!main_v_q) begin
                    main_v_d = 1'b1;
                    main_d_d = in_data;
                end else begin
                    skid_v_d = 1'b1;
                    skid_d_d = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_v_q <= 1'b0;
            skid_d_q <= RESET_VAL;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end
`else
    assign in_ready = !hold && (!main_v_q || out_ready);

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = RESET_VAL;
        end else if (!hold) begin
            if (accept) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end else if (emit) begin
                main_v_d = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_q <= 1'b0;
            main_d_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: an occupancy/FIFO reference model drives a
// scoreboard queue; works with or without PIPE_SKID_EN.
module tb_pipe_stage_hs;

    localparam int               WIDTH = 32;
    localparam int               CNT_W = 4;
    localparam logic [WIDTH-1:0] RV    = 32'hDEAD_BEEF;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             hold = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] xfer_cnt;

    pipe_stage_hs #(.WIDTH(WIDTH), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] last = RV;
    logic [CNT_W-1:0] mcnt = '0;
    logic             acc_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Check at negedge against the model, then advance the model at the posedge.
    task automatic cyc();
        logic m_vld, m_rdy, acc, emi;
        @(negedge clk);
        m_vld = (sb.size() > 0) && !hold;
        m_rdy = !hold && ((CAP == 2) ? (sb.size() < 2) : (sb.size() == 0 || out_ready));
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, m_vld);
        chk("out_data", out_data, (sb.size() > 0) ? sb[0] : last);
        chk("xfer_cnt", xfer_cnt, mcnt);
        @(posedge clk);
        if (flush) begin
            sb.delete();
            last = RV;
        end else if (!hold) begin
            acc = in_valid && m_rdy;
            emi = m_vld && out_ready;
            if (emi) begin
                last = sb.pop_front();
                mcnt = mcnt + 1'b1;
            end
            if (acc) begin
                sb.push_back(in_data);
                acc_seen = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, RV);
        chk("rst_xfer_cnt", xfer_cnt, '0);
        @(posedge clk);
        #2 reset = 1'b0;
        sb.delete();
        last = RV;
        mcnt = '0;
        #1;
    endtask

    task automatic put(input logic [WIDTH-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        acc_seen = 1'b0;
        while (!acc_seen && n < 20) begin
            cyc();
            n++;
        end
        chk("put_accepted", acc_seen, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] c0;
        int               n;
        #3 reset = 1'b1;
        #1;
        chk("por_out_valid", out_valid, 1'b0);
        chk("por_out_data", out_data, RV);
        chk("por_xfer_cnt", xfer_cnt, '0);
        #3 reset = 1'b0;
        #1;

        // Streaming 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("stream_cnt", xfer_cnt, 4'd8);

        // Backpressure 0xA, 0xB
        do_reset();
        out_ready = 1'b0;
        put(32'hA);
        in_valid = 1'b1;
        in_data  = 32'hB;
        acc_seen = 1'b0;
        cyc();
        cyc();
        chk("bp_hold_data", out_data, 32'hA);
        out_ready = 1'b1;
        n = 0;
        while (!acc_seen && n < 10) begin
            cyc();
            n++;
        end
        chk("bp_b_accepted", acc_seen, 1'b1);
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("bp_cnt", xfer_cnt, 4'd2);

        // Flush with entries held and a live input
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1;
        cyc();
        in_data = 32'h2;
        cyc();
        c0 = xfer_cnt;
        flush = 1'b1;
        out_ready = 1'b1;
        in_data = 32'hC;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_data", out_data, RV);
        chk("flush_cnt", xfer_cnt, c0);
        repeat (3) cyc();

        // Hold for 3 cycles, then release
        out_ready = 1'b0;
        put(32'h5);
        hold = 1'b1;
        out_ready = 1'b1;
        c0 = xfer_cnt;
        repeat (3) cyc();
        chk("hold_cnt", xfer_cnt, c0);
        hold = 1'b0;
        cyc();
        chk("hold_release_cnt", xfer_cnt, c0 + 1'b1);
        chk("hold_release_data", out_data, 32'h5);

        // Hold and flush together
        out_ready = 1'b0;
        put(32'h7);
        hold = 1'b1;
        flush = 1'b1;
        cyc();
        hold = 1'b0;
        flush = 1'b0;
        chk("holdflush_out_valid", out_valid, 1'b0);
        chk("holdflush_out_data", out_data, RV);
        cyc();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        hold = 1'b0;
        flush = 1'b0;

        // Reset while holding data
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h99;
        cyc();
        in_valid = 1'b0;
        do_reset();
        cyc();

        // Counter wrap: 17 emits on a 4-bit counter
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(32'h100 + i);
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("wrap_cnt", xfer_cnt, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
